// File: rtl/fir_pkg.sv
// Shared FIR definitions: controller state encoding, Q1.15 constants and the
// width helpers used by the shift/round/saturate stage.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, MAC, DONE} fir_state_t;

  localparam int Q_WIDTH = 16;
  localparam int Q_SHIFT = Q_WIDTH - 1;
  localparam logic signed [Q_WIDTH-1:0] Q_MAX = 16'sh7FFF;
  localparam logic signed [Q_WIDTH-1:0] Q_MIN = 16'sh8000;
  localparam longint ROUND_OFFSET = longint'(1) << (Q_WIDTH - 2);

  function automatic int q_shift(input int data_width);
    return data_width - 1;
  endfunction

  // Half an output LSB, expressed as a bit position in the accumulator.
  function automatic int round_bit(input int data_width);
    return data_width - 2;
  endfunction

endpackage

// File: rtl/fir_sat.sv
// Accumulator-to-output conversion: optional round-half-up, arithmetic shift
// by DATA_WIDTH-1, then clamp into the signed DATA_WIDTH range.
module fir_sat
  import fir_pkg::*;
#(
  parameter int ACC_WIDTH  = 37,
  parameter int DATA_WIDTH = 16,
  parameter bit ROUND_EN   = 1'b0
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  output logic signed [DATA_WIDTH-1:0] y
);

  localparam int SHIFT = q_shift(DATA_WIDTH);
  // One guard bit so the rounding offset can never wrap the sum.
  localparam int EXT   = ACC_WIDTH + 1;
  localparam logic signed [EXT-1:0] OFFSET = ROUND_EN ? (EXT'(1) << round_bit(DATA_WIDTH)) : '0;
  localparam logic signed [EXT-1:0] MAX_V  = (EXT'(1) << SHIFT) - EXT'(1);
  localparam logic signed [EXT-1:0] MIN_V  = -(EXT'(1) << SHIFT);

  logic signed [EXT-1:0] acc_ext;
  logic signed [EXT-1:0] rounded;
  logic signed [EXT-1:0] shifted;

  always_comb begin
    acc_ext = {acc[ACC_WIDTH-1], acc};
    rounded = acc_ext + OFFSET;
    shifted = rounded >>> SHIFT;
    if (shifted > MAX_V) begin
      y = MAX_V[DATA_WIDTH-1:0];
    end else if (shifted < MIN_V) begin
      y = MIN_V[DATA_WIDTH-1:0];
    end else begin
      y = shifted[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fir_mac_ctrl.sv
// FIR MAC controller: walks the circular sample RAM backwards from newest and
// the coefficient RAM forwards, one Q15 product per cycle, one y per start.
// Build option: define FIR_ROUND_EN for round-half-up instead of truncation.
module fir_mac_ctrl
  import fir_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16,
  parameter int TAPS       = 32,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] newest,
  output logic [ADDR_WIDTH-1:0] smp_adres,
  output logic [ADDR_WIDTH-1:0] coef_adres,
  input  logic [DATA_WIDTH-1:0] smp_data,
  input  logic [DATA_WIDTH-1:0] coef_data,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  y_valid
);

`ifdef FIR_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  localparam int PROD_WIDTH = 2*DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] K_LAST = ADDR_WIDTH'(TAPS - 1);

  fir_state_t              state_reg;
  logic [ADDR_WIDTH-1:0]   base_reg;
  logic [ADDR_WIDTH-1:0]   k_reg;
  logic [ADDR_WIDTH-1:0]   addr_idx_reg;
  logic signed [ACC_WIDTH-1:0] acc_reg;

  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  acc_next;
  logic signed [DATA_WIDTH-1:0] sat_y;

  assign prod     = $signed(smp_data) * $signed(coef_data);
  assign acc_next = acc_reg + {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};

  // Fed from acc_next so y lands in the same edge as the last product.
  fir_sat #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ROUND_EN   (ROUND_EN)
  ) u_sat (
    .acc (acc_next),
    .y   (sat_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      base_reg     <= '0;
      k_reg        <= '0;
      addr_idx_reg <= '0;
      acc_reg      <= '0;
      smp_adres    <= '0;
      coef_adres   <= '0;
      busy         <= 1'b0;
      y            <= '0;
      y_valid      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          y_valid <= 1'b0;
          if (start) begin
            // Address for k=0 goes out with the accept so FETCH covers RAM latency.
            state_reg    <= FETCH;
            base_reg     <= newest;
            k_reg        <= '0;
            acc_reg      <= '0;
            smp_adres    <= newest;
            coef_adres   <= '0;
            addr_idx_reg <= ADDR_WIDTH'(1);
            busy         <= 1'b1;
          end
        end
        FETCH: begin
          smp_adres    <= base_reg - addr_idx_reg;
          coef_adres   <= addr_idx_reg;
          addr_idx_reg <= addr_idx_reg + ADDR_WIDTH'(1);
          state_reg    <= MAC;
        end
        MAC: begin
          acc_reg      <= acc_next;
          k_reg        <= k_reg + ADDR_WIDTH'(1);
          smp_adres    <= base_reg - addr_idx_reg;
          coef_adres   <= addr_idx_reg;
          addr_idx_reg <= addr_idx_reg + ADDR_WIDTH'(1);
          if (k_reg == K_LAST) begin
            state_reg <= DONE;
            y         <= sat_y;
            y_valid   <= 1'b1;
          end
        end
        DONE: begin
          y_valid   <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Self-checking bench for fir_mac_ctrl with behavioural sample/coef RAMs and a
// plain-arithmetic convolution reference model.
module tb_fir_mac_ctrl;
  import fir_pkg::*;

  localparam int AW = 5;
  localparam int DW = 16;
  localparam int TAPS = 32;
  localparam int DEPTH = 1 << AW;
  localparam int LAT = TAPS + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] newest = '0;
  logic [AW-1:0] smp_adres, coef_adres;
  logic [DW-1:0] smp_data = '0, coef_data = '0;
  logic          busy, y_valid;
  logic [DW-1:0] y;

  logic signed [DW-1:0] smp_mem  [DEPTH];
  logic signed [DW-1:0] coef_mem [DEPTH];

  int tests_run = 0;
  int tests_failed = 0;

  fir_mac_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAPS(TAPS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .newest     (newest),
    .smp_adres  (smp_adres),
    .coef_adres (coef_adres),
    .smp_data   (smp_data),
    .coef_data  (coef_data),
    .busy       (busy),
    .y          (y),
    .y_valid    (y_valid)
  );

  always #5 clk = ~clk;

  // Registered-read RAM models.
  always @(posedge clk) begin
    smp_data  <= smp_mem[smp_adres];
    coef_data <= coef_mem[coef_adres];
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic fill_mems(input logic signed [DW-1:0] xv, input logic signed [DW-1:0] cv);
    for (int i = 0; i < DEPTH; i++) begin
      smp_mem[i]  = xv;
      coef_mem[i] = cv;
    end
  endtask

  task automatic random_mems();
    for (int i = 0; i < DEPTH; i++) begin
      smp_mem[i]  = DW'($urandom);
      coef_mem[i] = DW'($urandom);
    end
  endtask

  // y[n] = sum c[k]*x[n-k], scaled back to Q15 and clamped.
  function automatic logic [DW-1:0] ref_y(input logic [AW-1:0] n);
    longint acc = 0;
    for (int k = 0; k < TAPS; k++) begin
      int idx = (int'(n) - k + DEPTH) % DEPTH;
      acc += longint'(coef_mem[k]) * longint'(smp_mem[idx]);
    end
`ifdef FIR_ROUND_EN
    acc += ROUND_OFFSET;
`endif
    acc = acc >>> Q_SHIFT;
    if (acc > longint'(Q_MAX)) acc = longint'(Q_MAX);
    if (acc < longint'(Q_MIN)) acc = longint'(Q_MIN);
    return DW'(acc);
  endfunction

  // Runs one operation: start in cycle 0, optional extra start at pulse_c,
  // newest scrambled while busy. Stops at the negedge of the y_valid cycle.
  task automatic run_op(input logic [AW-1:0] n, input int pulse_c,
                        output logic [DW-1:0] y_o, output int lat,
                        output int bad, output bit wrap_seen);
    bad = 0; lat = -1; wrap_seen = 1'b0; y_o = '0;
    @(posedge clk); #1;
    start = 1'b1; newest = n;
    @(negedge clk);
    if (busy !== 1'b0 || y_valid !== 1'b0) bad++;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      start  = (c == pulse_c);
      newest = AW'($urandom);
      @(negedge clk);
      if (coef_adres == AW'(3) && smp_adres == AW'(31)) wrap_seen = 1'b1;
      if (busy !== 1'b1) bad++;
      if (y_valid === 1'b1) begin
        lat = c;
        y_o = y;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  longint'(busy), 0);
    check({tag, "_yv"},    longint'(y_valid), 0);
    check({tag, "_y"},     longint'(y), 0);
    check({tag, "_sadr"},  longint'(smp_adres), 0);
    check({tag, "_cadr"},  longint'(coef_adres), 0);
    check({tag, "_state"}, longint'(dut.state_reg == IDLE), 1);
  endtask

  logic [DW-1:0] y_a, y_b, y_ref;
  int lat, bad;
  bit wrap_seen;

  initial begin
    fill_mems('0, '0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Impulse
    fill_mems('0, '0);
    smp_mem[0] = 16'sh7FFF; coef_mem[0] = 16'sh4000;
    run_op(AW'(0), 0, y_a, lat, bad, wrap_seen);
`ifdef FIR_ROUND_EN
    check("impulse_y", longint'(y_a), 64'h4000);
`else
    check("impulse_y", longint'(y_a), 64'h3FFF);
`endif
    check("impulse_lat", lat, LAT);

    // Wrap-around addressing
    fill_mems('0, '0);
    smp_mem[31] = 16'sh1234; coef_mem[3] = 16'sh7FFF;
    run_op(AW'(2), 0, y_a, lat, bad, wrap_seen);
`ifdef FIR_ROUND_EN
    check("wrap_y", longint'(y_a), 64'h1234);
`else
    check("wrap_y", longint'(y_a), 64'h1233);
`endif
    check("wrap_addr31", longint'(wrap_seen), 1);
    check("wrap_lat", lat, LAT);

    // Saturation both ways
    fill_mems(16'sh7FFF, 16'sh7FFF);
    run_op(AW'(7), 0, y_a, lat, bad, wrap_seen);
    check("sat_pos", longint'(y_a), 64'h7FFF);
    fill_mems(16'sh8000, 16'sh7FFF);
    run_op(AW'(9), 0, y_a, lat, bad, wrap_seen);
    check("sat_neg", longint'(y_a), 64'h8000);

    // Timing: ignored start at cycle 10, back-to-back start right after y_valid
    random_mems();
    y_ref = ref_y(AW'(12));
    run_op(AW'(12), 10, y_a, lat, bad, wrap_seen);
    check("timing_lat1", lat, LAT);
    check("timing_busy1", bad, 0);
    check("timing_y1", longint'(y_a), longint'(y_ref));
    run_op(AW'(12), 0, y_b, lat, bad, wrap_seen);
    check("b2b_lat", lat, LAT);
    check("b2b_busy", bad, 0);
    check("b2b_same_y", longint'(y_b), longint'(y_ref));
    @(posedge clk); #1;
    check("after_idle_busy", longint'(busy), 0);
    check("after_idle_yv", longint'(y_valid), 0);

    // Reset mid-operation
    @(posedge clk); #1;
    start = 1'b1; newest = AW'(5);
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    rst_n = 1'b1;
    random_mems();
    y_ref = ref_y(AW'(20));
    run_op(AW'(20), 0, y_a, lat, bad, wrap_seen);
    check("postrst_y", longint'(y_a), longint'(y_ref));
    check("postrst_lat", lat, LAT);

    // Addressing sweep with random contents
    for (int i = 0; i < 3; i++) begin
      logic [AW-1:0] nv;
      nv = (i == 0) ? AW'(0) : (i == 1) ? AW'(17) : AW'(31);
      random_mems();
      y_ref = ref_y(nv);
      run_op(nv, 0, y_a, lat, bad, wrap_seen);
      check($sformatf("sweep_n%0d_y", nv), longint'(y_a), longint'(y_ref));
      check($sformatf("sweep_n%0d_busy", nv), bad, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
